// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART frame-sender arbiter:
// FSM state encoding, default frame width and the sender's tx_done pulse length.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DRAIN     = 2'd3
    } arb_state_e;

    // Default width of one UART frame; must match the sender's data port.
    localparam int FRAME_W_DEF = 40;

    // Number of consecutive cycles the sender holds tx_done high per frame.
    localparam int TX_DONE_CYC = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// searching last+1, last+2, ... modulo NREQ, plus a flag that any request is set.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic [2:0]      grant_idx,
    output logic            any
);

    // Scan the requests starting just after the previous winner.
    always_comb begin
        int   idx;
        logic found;
        grant_idx = 3'd0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                grant_idx = 3'(idx);
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART frame sender among NREQ producers
// (key scanner, status reporter, debug dump).
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a frame whose
// tx_done never arrives within TIMEOUT_CYC cycles of launch.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [2:0]              cur_src,
    output logic                    tx_send,
    output logic [FRAME_W-1:0]      tx_data,
    input  logic                    tx_idle,
    input  logic                    tx_done,
    output logic                    timeout_err
);

    localparam logic [NREQ-1:0] ACK_LSB = NREQ'(1'b1);

    arb_state_e          r_state, w_state_nxt;
    logic [2:0]          r_last, w_last_nxt;
    logic                r_tx_done_q;
    logic [NREQ-1:0]     r_ack, w_ack_nxt;
    logic                r_busy;
    logic [2:0]          r_cur_src, w_cur_src_nxt;
    logic                r_tx_send, w_tx_send_nxt;
    logic [FRAME_W-1:0]  r_tx_data, w_tx_data_nxt;
    logic                r_timeout_err, w_timeout_err_nxt;
    logic [2:0]          w_grant;
    logic                w_any;
    logic                w_done_rise;
    logic [NREQ-1:0]     w_ack_one;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req       (req),
        .last      (r_last),
        .grant_idx (w_grant),
        .any       (w_any)
    );

    // Only the first cycle of the two-cycle tx_done pulse completes a frame.
    assign w_done_rise = tx_done & ~r_tx_done_q;
    assign w_ack_one   = ACK_LSB << r_cur_src;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_timeout;

    assign w_timeout = ((r_state == ST_LAUNCH) || (r_state == ST_WAIT_DONE)) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog count: zero while idle so it starts from 0 on LAUNCH entry.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
        end else if ((r_state == ST_LAUNCH) || (r_state == ST_WAIT_DONE)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_last_nxt        = r_last;
        w_ack_nxt         = '0;
        w_cur_src_nxt     = r_cur_src;
        w_tx_send_nxt     = r_tx_send;
        w_tx_data_nxt     = r_tx_data;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && tx_idle) begin
                    w_tx_data_nxt = req_data[int'(w_grant)*FRAME_W +: FRAME_W];
                    w_cur_src_nxt = w_grant;
                    w_tx_send_nxt = 1'b1;
                    w_state_nxt   = ST_LAUNCH;
                end else begin
                    w_tx_send_nxt = 1'b0;
                end
            end
            ST_LAUNCH: begin
                // Sender has taken the frame once its idle flag drops.
                if (!tx_idle) begin
                    w_tx_send_nxt = 1'b0;
                    w_state_nxt   = ST_WAIT_DONE;
                end else begin
                    w_tx_send_nxt = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                w_tx_send_nxt = 1'b0;
                if (w_done_rise) begin
                    w_ack_nxt   = w_ack_one;
                    w_last_nxt  = r_cur_src;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_DRAIN: begin
                // Let the second tx_done cycle pass and the sender settle.
                w_tx_send_nxt = 1'b0;
                if (tx_idle && !tx_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_tx_send_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // Abort overrides normal progress: ack the stuck source and move on.
        if (w_timeout) begin
            w_tx_send_nxt     = 1'b0;
            w_ack_nxt         = w_ack_one;
            w_last_nxt        = r_cur_src;
            w_timeout_err_nxt = 1'b1;
            w_state_nxt       = ST_IDLE;
        end else begin
            w_timeout_err_nxt = 1'b0;
        end
`endif
    end

    // State, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last        <= 3'(NREQ - 1);
            r_tx_done_q   <= 1'b0;
            r_ack         <= '0;
            r_busy        <= 1'b0;
            r_cur_src     <= 3'd0;
            r_tx_send     <= 1'b0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_tx_done_q   <= tx_done;
            r_ack         <= w_ack_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_cur_src     <= w_cur_src_nxt;
            r_tx_send     <= w_tx_send_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign ack         = r_ack;
    assign busy        = r_busy;
    assign cur_src     = r_cur_src;
    assign tx_send     = r_tx_send;
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (default build, watchdog disabled).
// The sender is played by hand: tx_idle falls one cycle after tx_send is seen,
// tx_done is held high for TX_DONE_CYC cycles, tx_idle returns one cycle later.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int FW   = 40;

    localparam logic [FW-1:0] F_SINGLE = 40'h11_2233_4455;
    localparam logic [FW-1:0] F0       = 40'hA0_A0A0_A0A0;
    localparam logic [FW-1:0] F1       = 40'hB1_B1B1_B1B1;
    localparam logic [FW-1:0] F2       = 40'hC2_C2C2_C2C2;
    localparam logic [FW-1:0] F3       = 40'hD3_D3D3_D3D3;
    localparam logic [FW-1:0] F1_NEW   = 40'h5A_5A5A_5A5A;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*FW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [2:0]           cur_src;
    logic                 tx_send;
    logic [FW-1:0]        tx_data;
    logic                 tx_idle;
    logic                 tx_done;
    logic                 timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .FRAME_W     (FW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .cur_src     (cur_src),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_idle     (tx_idle),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int idx, input logic [FW-1:0] val);
        req_data[idx*FW +: FW] = val;
    endtask

    task automatic check_reset();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_src", 64'(cur_src), 64'd0);
        chk("rst_tx_send", 64'(tx_send), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    endtask

    // One complete frame starting from IDLE with req pending and the sender idle.
    task automatic serve(input int src, input logic [FW-1:0] data,
                         input bit mutate, input logic [FW-1:0] newval);
        logic [NREQ-1:0] exp_ack;
        exp_ack = 4'b0001 << src;
        step();
        chk("launch_send", 64'(tx_send), 64'd1);
        chk("launch_data", 64'(tx_data), 64'(data));
        chk("launch_src", 64'(cur_src), 64'(src));
        chk("launch_busy", 64'(busy), 64'd1);
        step();
        chk("launch_hold", 64'(tx_send), 64'd1);
        tx_idle = 1'b0;
        step();
        chk("wait_send_low", 64'(tx_send), 64'd0);
        chk("wait_no_ack", 64'(ack), 64'd0);
        if (mutate) set_frame(1, newval);
        tx_done = 1'b1;
        step();
        chk("ack_pulse", 64'(ack), 64'(exp_ack));
        chk("drain_data", 64'(tx_data), 64'(data));
        chk("drain_busy", 64'(busy), 64'd1);
        req[src] = 1'b0;
        for (int k = 1; k < TX_DONE_CYC; k++) begin
            step();
            chk("ack_once", 64'(ack), 64'd0);
            chk("no_relaunch_done", 64'(tx_send), 64'd0);
        end
        tx_done = 1'b0;
        step();
        chk("drain_wait_idle", 64'(busy), 64'd1);
        chk("no_relaunch_idle", 64'(tx_send), 64'd0);
        chk("drain_data_hold", 64'(tx_data), 64'(data));
        tx_idle = 1'b1;
        step();
        chk("drain_exit", 64'(busy), 64'd0);
        chk("no_timeout_err", 64'(timeout_err), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = '0;
        tx_idle  = 1'b1;
        tx_done  = 1'b0;
        step();
        step();
        check_reset();
        rst = 1'b0;

        // Single request from source 0.
        set_frame(0, F_SINGLE);
        req = 4'b0001;
        serve(0, F_SINGLE, 1'b0, '0);
        step();
        chk("single_idle_busy", 64'(busy), 64'd0);
        chk("single_idle_ack", 64'(ack), 64'd0);

        // Fresh pointer, all four requests held: order 0,1,2,3.
        rst = 1'b1;
        step();
        check_reset();
        rst = 1'b0;
        set_frame(0, F0);
        set_frame(1, F1);
        set_frame(2, F2);
        set_frame(3, F3);
        req = 4'b1111;
        serve(0, F0, 1'b0, '0);
        serve(1, F1, 1'b0, '0);
        serve(2, F2, 1'b0, '0);
        serve(3, F3, 1'b0, '0);

        // Re-raise 0 and 2 after 3 was last: order 0,2.
        req = 4'b0101;
        serve(0, F0, 1'b0, '0);
        serve(2, F2, 1'b0, '0);

        // Source 1 frame changes mid-flight; next frame from 1 carries it.
        req = 4'b0010;
        serve(1, F1, 1'b1, F1_NEW);
        req = 4'b0010;
        serve(1, F1_NEW, 1'b0, '0);

        // Reset in WAIT_DONE with 1 and 2 pending; last was 1 so 2 wins first.
        req = 4'b0110;
        step();
        chk("pre_rst_src", 64'(cur_src), 64'd2);
        chk("pre_rst_send", 64'(tx_send), 64'd1);
        step();
        tx_idle = 1'b0;
        step();
        chk("pre_rst_wait", 64'(tx_send), 64'd0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst     = 1'b1;
        tx_idle = 1'b1;
        tx_done = 1'b0;
        step();
        check_reset();
        rst = 1'b0;
        serve(1, F1_NEW, 1'b0, '0);
        serve(2, F2, 1'b0, '0);
        step();
        chk("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
